// File: rtl/core_ctrl_pkg.sv
// Shared types for the NPU core sequencer: state encoding, inst payload layout and
// the inst bit-index map also used by core-level benches.
package core_ctrl_pkg;

  localparam int unsigned INST_W = 17;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NUM_W  = 4;
  localparam int unsigned CNT_W  = 5;

  localparam int unsigned OFIFO_RD   = 16;
  localparam int unsigned QK_ADD_MSB = 15;
  localparam int unsigned QK_ADD_LSB = 12;
  localparam int unsigned P_ADD_MSB  = 11;
  localparam int unsigned P_ADD_LSB  = 8;
  localparam int unsigned EXE        = 7;
  localparam int unsigned LOAD       = 6;
  localparam int unsigned QRD        = 5;
  localparam int unsigned QWR        = 4;
  localparam int unsigned KRD        = 3;
  localparam int unsigned KWR        = 2;
  localparam int unsigned PRD        = 1;
  localparam int unsigned PWR        = 0;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_WR_Q  = 4'd1,
    ST_WR_K  = 4'd2,
    ST_LD_K  = 4'd3,
    ST_GAP   = 4'd4,
    ST_EXE   = 4'd5,
    ST_DRAIN = 4'd6,
    ST_RD_P  = 4'd7,
    ST_DONE  = 4'd8
  } state_e;

  // Field order mirrors the inst bit-index map above, MSB first.
  typedef struct packed {
    logic              ofifo_rd;
    logic [ADDR_W-1:0] qk_add;
    logic [ADDR_W-1:0] p_add;
    logic              execute;
    logic              load;
    logic              qmem_rd;
    logic              qmem_wr;
    logic              kmem_rd;
    logic              kmem_wr;
    logic              pmem_rd;
    logic              pmem_wr;
  } inst_t;

endpackage

// File: rtl/core_ctrl_if.sv
// Host/core-side signal bundle of core_ctrl; slave is the controller view,
// master is the host/stimulus view.
interface core_ctrl_if;
  import core_ctrl_pkg::*;

  logic              start;
  logic [NUM_W-1:0]  num_q;
  logic [NUM_W-1:0]  num_k;
  logic              in_valid;
  logic              in_ready;
  logic              ofifo_valid;
  logic [INST_W-1:0] inst;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_idx;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, num_q, num_k, in_valid, ofifo_valid,
    input  in_ready, inst, rd_valid, rd_idx, busy, done, err
  );

  modport slave (
    input  start, num_q, num_k, in_valid, ofifo_valid,
    output in_ready, inst, rd_valid, rd_idx, busy, done, err
  );

endinterface

// File: rtl/core_ctrl_wdog.sv
// DRAIN wait counter and sticky error flag; only built when CORE_CTRL_WDOG_EN is defined.
`ifdef CORE_CTRL_WDOG_EN
module core_ctrl_wdog #(
  parameter int unsigned WDOG_CYC = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic drain_i,
  input  logic valid_i,
  input  logic clr_i,
  output logic fire_c_o,
  output logic err_o
);

  localparam int unsigned WAIT_W = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;

  // Fires on the WDOG_CYC-th consecutive empty DRAIN cycle.
  assign fire_c_o = drain_i && !valid_i && (wait_q == WAIT_W'(WDOG_CYC - 1));

  always_comb begin
    wait_d = '0;
    err_d  = err_q;
    if (drain_i && !valid_i && !fire_c_o) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    if (clr_i) begin
      err_d = 1'b0;
    end else if (fire_c_o) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule
`endif

// File: rtl/core_ctrl.sv
// Sequencer for one NPU core pass: Q/K load, K-to-array load, execute, OFIFO drain, psum read.
// Define CORE_CTRL_WDOG_EN to add the DRAIN watchdog (err output); otherwise DRAIN waits forever.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned col      = 8,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned WDOG_CYC = 64
) (
  input  logic       clk,
  input  logic       reset,
  core_ctrl_if.slave bus
);

  if (col == 0 || GAP_CYC < 1 || GAP_CYC > 15 || WDOG_CYC < 2) begin : g_param_chk
    $error("core_ctrl: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_W-1:0]  nq_q, nq_d;
  logic [NUM_W-1:0]  nk_q, nk_d;
  inst_t             inst_q, inst_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  nq_last, nk_last;
  logic              wdog_fire_c;
  logic              wdog_err;

  assign nq_last = CNT_W'(nq_q);
  assign nk_last = CNT_W'(nk_q);

  // Next state and next inst: inst is the registered decode of this cycle's state and inputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    nq_d       = nq_q;
    nk_d       = nk_q;
    inst_d     = '0;
    rd_valid_d = 1'b0;
    rd_idx_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          nq_d    = bus.num_q;
          nk_d    = bus.num_k;
          state_d = ST_WR_Q;
        end
      end
      ST_WR_Q: begin
        cnt_d = cnt_q;
        if (bus.in_valid) begin
          inst_d.qmem_wr = 1'b1;
          inst_d.qk_add  = ADDR_W'(cnt_q);
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == nq_last) state_d = ST_WR_K;
        end
      end
      ST_WR_K: begin
        cnt_d = cnt_q;
        if (bus.in_valid) begin
          inst_d.kmem_wr = 1'b1;
          inst_d.qk_add  = ADDR_W'(cnt_q);
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == nk_last) state_d = ST_LD_K;
        end
      end
      // Array load trails the K SRAM read by its one-cycle latency.
      ST_LD_K: begin
        if (cnt_q <= nk_last) begin
          inst_d.kmem_rd = 1'b1;
          inst_d.qk_add  = ADDR_W'(cnt_q);
        end
        inst_d.load = (cnt_q != '0);
        if (cnt_q == nk_last + CNT_W'(1)) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) state_d = ST_EXE;
      end
      ST_EXE: begin
        if (cnt_q <= nq_last) begin
          inst_d.qmem_rd = 1'b1;
          inst_d.qk_add  = ADDR_W'(cnt_q);
        end
        inst_d.execute = (cnt_q != '0);
        if (cnt_q == nq_last + CNT_W'(1)) state_d = ST_DRAIN;
      end
      // Show-ahead OFIFO: the row is on its output, so pop and store in one cycle.
      ST_DRAIN: begin
        cnt_d = cnt_q;
        if (bus.ofifo_valid) begin
          inst_d.ofifo_rd = 1'b1;
          inst_d.pmem_wr  = 1'b1;
          inst_d.p_add    = ADDR_W'(cnt_q);
          cnt_d           = cnt_q + CNT_W'(1);
          if (cnt_q == nq_last) state_d = ST_RD_P;
        end else if (wdog_fire_c) begin
          state_d = ST_DONE;
        end
      end
      ST_RD_P: begin
        if (cnt_q <= nq_last) begin
          inst_d.pmem_rd = 1'b1;
          inst_d.p_add   = ADDR_W'(cnt_q);
        end
        if (cnt_q != '0) begin
          rd_valid_d = 1'b1;
          rd_idx_d   = ADDR_W'(cnt_q - CNT_W'(1));
        end
        if (cnt_q == nq_last + CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      nq_q       <= '0;
      nk_q       <= '0;
      inst_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nq_q       <= nq_d;
      nk_q       <= nk_d;
      inst_q     <= inst_d;
      rd_valid_q <= rd_valid_d;
      rd_idx_q   <= rd_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef CORE_CTRL_WDOG_EN
  core_ctrl_wdog #(
    .WDOG_CYC (WDOG_CYC)
  ) u_wdog (
    .clk_i    (clk),
    .rst_ni   (reset),
    .drain_i  (state_q == ST_DRAIN),
    .valid_i  (bus.ofifo_valid),
    .clr_i    ((state_q == ST_IDLE) && bus.start),
    .fire_c_o (wdog_fire_c),
    .err_o    (wdog_err)
  );
`else
  assign wdog_fire_c = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  // in_ready is a pure state decode so the host sees no input-to-output path.
  assign bus.in_ready = (state_q == ST_WR_Q) || (state_q == ST_WR_K);
  assign bus.inst     = inst_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_idx   = rd_idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = wdog_err;

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Sequencer for the single-core NPU datapath. It produces the 17-bit `inst` word that drives the core's Q/K SRAMs, MAC array, output FIFO and psum SRAM through one full pass:
- load Q rows, then K rows;
- load K into the array;
- execute Q rows;
- drain the OFIFO into psum memory;
- read psum memory back to the host.

It sits between the host/testbench stimulus port and the core's `inst` input.

## Interface
- `col`, 8, MAC array columns; sets the OFIFO drain width context only
- `GAP_CYC`, 4, idle cycles between the end of K-load and the start of execute (1..15)
- `WDOG_CYC`, 64, maximum DRAIN cycles without `ofifo_valid` (macro-gated)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request; sampled in IDLE only
- `num_q`  in  4  Q rows minus 1; latched on accepted `start`
- `num_k`  in  4  K rows minus 1; latched on accepted `start`
- `in_valid`  in  1  host has a `mem_in` word
- `in_ready`  out  1  controller accepts the `mem_in` word this cycle
- `ofifo_valid`  in  1  core OFIFO holds a complete row
- `inst`  out  17  core instruction: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
- `rd_valid`  out  1  core `out` carries psum row `rd_idx`
- `rd_idx`  out  4  psum row index for `rd_valid`
- `busy`  out  1  high whenever not in IDLE
- `done`  out  1  one-cycle pulse on DONE exit
- `err`  out  1  watchdog fired; sticky until next accepted `start`

## Operation
- States and transitions:
  - IDLE→WR_Q on `start`.
  - WR_Q→WR_K after num_q+1 writes.
  - WR_K→LD_K after num_k+1 writes.
  - LD_K→GAP→EXE.
  - EXE→DRAIN.
  - DRAIN→RD_P after num_q+1 rows.
  - RD_P→DONE.
  - DONE→IDLE after 1 cycle.
- Counter `cnt` (5 bits) clears on every state entry.
- WR_Q / WR_K:
  - `in_ready`=1.
  - When `in_valid`: qmem_wr (or kmem_wr)=1, qkmem_add=`cnt`, `cnt`++.
  - `in_valid`=0 stalls with all write bits low.
- LD_K runs num_k+2 cycles:
  - Cycles 0..num_k: kmem_rd=1, qkmem_add=`cnt`.
  - Cycles 1..num_k+1: inst[6]=1. This matches the 1-cycle SRAM read latency.
- GAP: `inst`=0 for `GAP_CYC` cycles.
- EXE runs num_q+2 cycles:
  - Cycles 0..num_q: qmem_rd=1, qkmem_add=`cnt`.
  - Cycles 1..num_q+1: inst[7]=1.
- DRAIN:
  - Each cycle with `ofifo_valid`: ofifo_rd=1 and pmem_wr=1 in the same cycle, pmem_add=`cnt`, `cnt`++.
  - The OFIFO output is show-ahead.
- RD_P:
  - Cycles 0..num_q: pmem_rd=1, pmem_add=`cnt`.
  - `rd_valid`/`rd_idx` follow one cycle later.
  - The state exits after the last `rd_valid`, num_q+2 cycles total.
- `start` outside IDLE is ignored.
- `num_q`/`num_k` changes after latch are ignored.
- `in_valid` outside WR_Q/WR_K is ignored; `in_ready`=0 there.
- Reset mid-operation:
  - Immediate return to IDLE.
  - All `inst` bits 0, counters 0, `err` 0.
  - The core's SRAM contents are not cleared.

## Timing
- Reset values:
  - `inst`=0, `in_ready`=0, `rd_valid`=0, `rd_idx`=0, `busy`=0, `done`=0, `err`=0.
- All outputs are registered except `in_ready`, which is decoded from the state register (no combinational path from inputs).
- `start` accepted at edge t: `busy`=1 and WR_Q active from t+1.
- Total latency with no stalls:
  - (num_q+1) + (num_k+1) + (num_k+2) + GAP_CYC + (num_q+2) + drain + (num_q+2) + 1 cycles.
- Boundaries:
  - num_q=0 / num_k=0: single-row passes, no special casing.
  - num=15: `cnt` reaches 16 without wrapping the 4-bit address, since only `cnt`[3:0] is driven.

## Configuration
- `CORE_CTRL_WDOG_EN` defined:
  - In DRAIN, a wait counter counts consecutive cycles with `ofifo_valid`=0 and resets on each row drained.
  - On reaching `WDOG_CYC`: `err`=1, jump to DONE, skip RD_P.
- Undefined:
  - DRAIN waits indefinitely.
  - `err` is tied 0 and the wait counter is absent.

## Structure
- `core_ctrl_pkg`: state enum and the `inst` bit-index localparams (OFIFO_RD=16, QK_ADD_MSB=15, QK_ADD_LSB=12, P_ADD_MSB=11, P_ADD_LSB=8, EXE=7, LOAD=6, QRD=5, QWR=4, KRD=3, KWR=2, PRD=1, PWR=0), shared with the core testbench.
- Sub-module `core_ctrl_wdog` (wait counter plus sticky flag), instantiated only under `CORE_CTRL_WDOG_EN`.

## Test plan
- Reset mid-EXE: assert `reset` low at EXE cycle 2 → same cycle `inst`=0, `busy`=0; after release, a `start` runs a clean pass.
- Nominal pass, num_q=7, num_k=7, `in_valid` always high, `ofifo_valid` high from drain entry:
  - 8 qmem_wr to addresses 0..7, then 8 kmem_wr;
  - LD_K lasts 9 cycles with inst[6] lagging kmem_rd by 1;
  - 8 pmem_wr to pmem_add 0..7;
  - `rd_idx` 0..7 with `rd_valid`;
  - `done` pulses once.
- `in_valid` toggling 1,0,1,0 in WR_Q with num_q=3 → 4 writes over 7 cycles, addresses 0..3 contiguous, no write on low cycles.
- num_q=0, num_k=0 → exactly one write, load, execute, drain and read each; total 1+1+2+GAP_CYC+2+1+2+1 cycles.
- `start` pulsed during DRAIN → ignored; latched num_q unchanged, single `done`.
- Macro on, `ofifo_valid` held 0 → `err`=1 after 64 DRAIN cycles, DONE next, `done` pulse, no pmem_rd; macro off → `busy` stays 1.
